muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M-style multiply/divide unit: 2-cycle multiply, XLEN+2-cycle restoring divide.
// Latches operands on accept; busy stalls the pipe until the one-cycle done pulse.
module muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic is_special(input logic [2:0] o, input logic [XLEN-1:0] x,
                                      input logic [XLEN-1:0] y);
    return o[2] && ((y == '0) || (!o[0] && x == MIN_NEG && y == '1));
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic [2:0] o, input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
    if (y == '0) return o[1] ? x : '1;
    return o[1] ? '0 : x;
  endfunction

  logic            accept;
  logic            sgn_div;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] q_fix, r_fix;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0] mul_res;

  assign accept  = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
  assign sgn_div = !op_q[0];
  assign abs_a   = (sgn_div && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b   = (sgn_div && b_q[XLEN-1]) ? -b_q : b_q;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  assign q_fix = (sgn_div && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_d : quo_d;
  assign r_fix = (sgn_div && a_q[XLEN-1]) ? -rem_d : rem_d;

  // a is signed for MULH/MULHSU, b only for MULH; MUL's low half is sign-agnostic.
  assign ext_a   = {{XLEN{(op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10) & a_q[XLEN-1]}}, a_q};
  assign ext_b   = {{XLEN{(op_q[1:0] == 2'b01) & b_q[XLEN-1]}}, b_q};
  assign prod    = ext_a * ext_b;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_MUL: begin
        state_d  = S_DONE;
        result_d = op_q[2] ? special_res(op_q, a_q, b_q) : mul_res;
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          rem_d = '0;
          quo_d = abs_a;
          dvs_d = abs_b;
        end else begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CW'(XLEN)) begin
            state_d  = S_DONE;
            result_d = is_special(op_q, a_q, b_q) ? special_res(op_q, a_q, b_q)
                                                  : (op_q[1] ? r_fix : q_fix);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      op_d    = op;
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      state_d = (op[2] && !(FAST_SPECIAL && is_special(op, a, b))) ? S_DIV : S_MUL;
    end
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed XLEN=32 cases on fast/slow special-case builds,
// then an XLEN=8 random regression against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Two XLEN=32 instances share stimulus; only FAST_SPECIAL differs.
  logic        start32, flush32;
  logic [2:0]  op32;
  logic [31:0] a32, b32;
  logic        busyA, doneA, busyB, doneB;
  logic [31:0] resA, resB;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  result8;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dutA (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busyA), .done(doneA), .result(resA));

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dutB (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busyB), .done(doneB), .result(resB));

  muldiv_unit #(.XLEN(8), .FAST_SPECIAL(1'b1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .result(result8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions; valid for w <= 32.
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] o,
                                            input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask, ux, uy, pr;
    longint sx, sy, q, r;
    mask = (64'd1 << w) - 64'd1;
    ux = x & mask;
    uy = y & mask;
    sx = longint'(ux << (64 - w)) >>> (64 - w);
    sy = longint'(uy << (64 - w)) >>> (64 - w);
    case (o)
      3'b000: return (ux * uy) & mask;
      3'b001: begin pr = sx * sy;           return (pr >> w) & mask; end
      3'b010: begin pr = sx * longint'(uy); return (pr >> w) & mask; end
      3'b011: begin pr = ux * uy;           return (pr >> w) & mask; end
      default: begin
        if (uy == 0) begin
          q = longint'(mask); r = longint'(ux);
        end else if (!o[0] && sx == -(longint'(1) << (w - 1)) && sy == -1) begin
          q = longint'(ux); r = 0;
        end else if (!o[0]) begin
          q = sx / sy; r = sx % sy;
        end else begin
          q = longint'(ux / uy); r = longint'(ux % uy);
        end
        return (o[1] ? r : q) & mask;
      end
    endcase
  endfunction

  // Issue one op to both 32-bit instances and track each one's done/busy/result.
  task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int la, input int lb);
    int ca, cb;
    logic okA, okB;
    logic [31:0] ra, rb, pa, pb;
    pa = resA; pb = resB;
    ca = 0; cb = 0; okA = 1'b1; okB = 1'b1; ra = '0; rb = '0;
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    step();
    // A second start with different operands while busy must be ignored.
    op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) start32 = 1'b0;
      if (ca == 0) begin
        if (doneA) begin ca = c; ra = resA; if (busyA !== 1'b0) okA = 1'b0; end
        else if (busyA !== 1'b1 || resA !== pa) okA = 1'b0;
      end else if (doneA) okA = 1'b0;
      if (cb == 0) begin
        if (doneB) begin cb = c; rb = resB; if (busyB !== 1'b0) okB = 1'b0; end
        else if (busyB !== 1'b1 || resB !== pb) okB = 1'b0;
      end else if (doneB) okB = 1'b0;
      if (ca != 0 && cb != 0) break;
      step();
    end
    chk({tag, "_latA"}, 64'(ca), 64'(la));
    chk({tag, "_resA"}, 64'(ra), 64'(exp));
    chk({tag, "_seqA"}, 64'(okA), 64'd1);
    chk({tag, "_latB"}, 64'(cb), 64'(lb));
    chk({tag, "_resB"}, 64'(rb), 64'(exp));
    chk({tag, "_seqB"}, 64'(okB), 64'd1);
    step();
  endtask

  initial begin
    logic [2:0] cur_op;
    logic [7:0] cur_a, cur_b;
    int lat, exp_lat;
    logic bz, spec;

    rst = 1'b1; start32 = 0; flush32 = 0; op32 = 0; a32 = 0; b32 = 0;
    start8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_busyA", 64'(busyA), 0);
    chk("rst_doneA", 64'(doneA), 0);
    chk("rst_resA", 64'(resA), 0);
    chk("rst_busyB", 64'(busyB), 0);
    chk("rst_res8", 64'(result8), 0);

    run32("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 2);
    run32("mul_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2, 2);
    run32("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 2);
    run32("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 2);
    run32("div_m7", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34);
    run32("rem_m7", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34);
    run32("divu_big", 3'b101, 32'hFFFF_FFF0, 32'd3, 32'h5555_5550, 34, 34);
    run32("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 34);
    run32("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, 2, 34);
    run32("div_z_neg", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 2, 34);
    run32("rem_z_neg", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, 34);
    run32("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 34);
    run32("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 34);

    // Flush a DIV at cycle 10: no done, result retained, new start at cycle 11 accepted.
    op32 = 3'b100; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
    step();
    start32 = 1'b0;
    bz = 1'b1;
    for (int c = 1; c < 10; c++) begin
      if (doneA || doneB || !busyA || !busyB) bz = 1'b0;
      step();
    end
    flush32 = 1'b1;
    step();
    flush32 = 1'b0;
    chk("flush_pre", 64'(bz), 1);
    chk("flush_busyA", 64'(busyA), 0);
    chk("flush_busyB", 64'(busyB), 0);
    chk("flush_doneA", 64'(doneA), 0);
    chk("flush_resA", 64'(resA), 64'h0);
    run32("post_flush", 3'b000, 32'd3, 32'd4, 32'd12, 2, 2);

    // Flush and start together: the start is dropped.
    op32 = 3'b000; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1; flush32 = 1'b1;
    step();
    start32 = 1'b0; flush32 = 1'b0;
    chk("fs_busy", 64'(busyA), 0);
    step();
    chk("fs_done", 64'(doneA), 0);
    chk("fs_res", 64'(resA), 64'd12);

    // Reset at cycle 5 of a DIVU, with a start held in the same cycle.
    op32 = 3'b101; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    step();
    start32 = 1'b0;
    for (int c = 1; c < 5; c++) step();
    rst = 1'b1; start32 = 1'b1; op32 = 3'b000;
    step();
    rst = 1'b0; start32 = 1'b0;
    chk("rst_mid_busyA", 64'(busyA), 0);
    chk("rst_mid_doneA", 64'(doneA), 0);
    chk("rst_mid_resA", 64'(resA), 0);
    chk("rst_mid_busyB", 64'(busyB), 0);
    chk("rst_mid_resB", 64'(resB), 0);
    step();
    chk("rst_start_ign", 64'(busyA), 0);
    run32("after_rst", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 34);

    // XLEN=8 random regression with randomly chained back-to-back starts.
    cur_op = 3'($urandom); cur_a = 8'($urandom); cur_b = 8'($urandom);
    op8 = cur_op; a8 = cur_a; b8 = cur_b; start8 = 1'b1;
    for (int n = 0; n < 300; n++) begin
      step();
      start8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      spec = cur_op[2] && (cur_b == 8'h00 || (!cur_op[0] && cur_a == 8'h80 && cur_b == 8'hFF));
      exp_lat = (cur_op[2] && !spec) ? 10 : 2;
      lat = 1; bz = 1'b1;
      while (!done8 && lat < 20) begin
        if (busy8 !== 1'b1) bz = 1'b0;
        step();
        lat++;
      end
      chk("r8_done", 64'(done8), 1);
      chk("r8_res", 64'(result8), ref_model(8, cur_op, 64'(cur_a), 64'(cur_b)));
      chk("r8_lat", 64'(lat), 64'(exp_lat));
      chk("r8_busy", 64'(bz && !busy8), 1);
      cur_op = 3'($urandom);
      case ($urandom_range(3, 0))
        0: cur_a = 8'h80;
        1: cur_a = 8'hFF;
        default: cur_a = 8'($urandom);
      endcase
      case ($urandom_range(4, 0))
        0: cur_b = 8'h00;
        1: cur_b = 8'hFF;
        default: cur_b = 8'($urandom);
      endcase
      if ($urandom_range(1, 0) == 0) begin
        step();
        chk("r8_nodup", 64'(done8), 0);
        chk("r8_idle", 64'(busy8), 0);
      end
      op8 = cur_op; a8 = cur_a; b8 = cur_b; start8 = 1'b1;
    end
    start8 = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
